// File: rtl/hazard_unit.sv
// Hazard and sequencing controller for a 5-stage LEGv8 pipeline.
// Stalls on load-use hazards, squashes wrong-path stages on a taken branch
// resolved in MEM, selects EX operand forwarding and counts stall/flush events.
//
// state | meaning
// RUN   | normal flow; hazard and branch detection active
// STALL | extra load-use bubble cycles beyond the first
// FLUSH | extra flush cycles beyond the first after a taken branch
module hazard_unit #(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_readmem,
    input  logic             ex_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             en_jump,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_events,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [4:0] XZR = 5'd31;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hz;
    logic       take_stall, take_flush;
    logic       stall_inc, flush_inc;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        hz = ex_readmem && ex_regwrite && (ex_rd != XZR) &&
             ((id_use_rn && (ex_rd == id_rn)) || (id_use_rm && (ex_rd == id_rm)));
    end

    // State and bubble/flush counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and stall/flush outputs; reset forces pass-through defaults.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        take_stall   = 1'b0;
        take_flush   = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (en_jump)
                        take_flush = 1'b1;
                    else if (hz)
                        take_stall = 1'b1;
                end
                STALL: begin
                    if (en_jump) begin
                        take_flush = 1'b1;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        cnt_nxt      = cnt - 4'd1;
                        if (cnt <= 4'd1)
                            state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    cnt_nxt      = cnt - 4'd1;
                    if (cnt <= 4'd1)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase

            if (take_flush) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                flush_inc    = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 4'(FLUSH_CYCLES - 1);
                end else begin
                    state_nxt = RUN;
                end
            end

            if (take_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_inc    = 1'b1;
                if (LOAD_STALL > 1) begin
                    state_nxt = STALL;
                    cnt_nxt   = 4'(LOAD_STALL - 1);
                end else begin
                    state_nxt = RUN;
                end
            end
        end
    end

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            if (mem_regwrite && (mem_rd != XZR) && (mem_rd == ex_rn))
                fwd_a = 2'b10;
            else if (wb_regwrite && (wb_rd != XZR) && (wb_rd == ex_rn))
                fwd_a = 2'b01;
            if (mem_regwrite && (mem_rd != XZR) && (mem_rd == ex_rm))
                fwd_b = 2'b10;
            else if (wb_regwrite && (wb_rd != XZR) && (wb_rd == ex_rm))
                fwd_b = 2'b01;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_events <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_events != '1))
                stall_events <= stall_events + CNT_W'(1);
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default instance and a small instance
// with 3-cycle stall/flush and 4-bit counters, driven from shared inputs.
module tb_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic       id_use_rn, id_use_rm, ex_readmem, ex_regwrite;
    logic       mem_regwrite, wb_regwrite, en_jump;

    logic        d_pc, d_ifid, d_bub, d_fif, d_fie, d_fem;
    logic [1:0]  d_fa, d_fb;
    logic [15:0] d_se, d_fe;
    logic        s_pc, s_ifid, s_bub, s_fif, s_fie, s_fem;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  s_se, s_fe;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    hazard_unit u_dut (
        .clock(clock), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_readmem(ex_readmem), .ex_regwrite(ex_regwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .en_jump(en_jump),
        .pc_write(d_pc), .if_id_write(d_ifid), .id_ex_bubble(d_bub),
        .flush_if_id(d_fif), .flush_id_ex(d_fie), .flush_ex_mem(d_fem),
        .fwd_a(d_fa), .fwd_b(d_fb), .stall_events(d_se), .flush_events(d_fe)
    );

    hazard_unit #(.LOAD_STALL(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_small (
        .clock(clock), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_readmem(ex_readmem), .ex_regwrite(ex_regwrite),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .en_jump(en_jump),
        .pc_write(s_pc), .if_id_write(s_ifid), .id_ex_bubble(s_bub),
        .flush_if_id(s_fif), .flush_id_ex(s_fie), .flush_ex_mem(s_fem),
        .fwd_a(s_fa), .fwd_b(s_fb), .stall_events(s_se), .flush_events(s_fe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        {id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rn, id_use_rm, ex_readmem, ex_regwrite} = '0;
        {mem_regwrite, wb_regwrite, en_jump} = '0;
    endtask

    task automatic load_use_rn2();
        ex_rd = 5'd2; ex_readmem = 1'b1; ex_regwrite = 1'b1;
        id_rn = 5'd2; id_use_rn = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Hazard, branch and forwarding conditions all present during reset.
        load_use_rn2();
        en_jump = 1'b1;
        ex_rn = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1;
        tick();
        check("rst_pc_write", d_pc, 1);
        check("rst_bubble", d_bub, 0);
        check("rst_flush", {d_fif, d_fie, d_fem}, 3'b000);
        check("rst_fwd_a", d_fa, 2'b00);
        check("rst_events", {d_se, d_fe}, 0);
        clear_inputs();
        reset = 1'b0;
        tick();

        // Load-use hazard on rn: one bubble in default, three in the small instance.
        load_use_rn2();
        #1;
        check("hz_pc_write", d_pc, 0);
        check("hz_if_id_write", d_ifid, 0);
        check("hz_bubble", d_bub, 1);
        tick();
        clear_inputs();
        #1;
        check("hz_released", d_pc, 1);
        check("hz_stall_events", d_se, 1);
        check("ls3_stall_c2", {s_pc, s_bub}, 2'b01);
        tick();
        check("ls3_stall_c3", {s_pc, s_bub}, 2'b01);
        tick();
        check("ls3_run_again", {s_pc, s_bub}, 2'b10);
        check("ls3_stall_events", s_se, 1);

        // XZR destination never stalls.
        ex_rd = 5'd31; ex_readmem = 1'b1; ex_regwrite = 1'b1;
        id_rn = 5'd31; id_use_rn = 1'b1;
        #1;
        check("xzr_no_stall", {d_pc, d_ifid, d_bub}, 3'b110);
        // Hazard through rm, and no hazard when rm is not used.
        clear_inputs();
        ex_rd = 5'd7; ex_readmem = 1'b1; ex_regwrite = 1'b1; id_rm = 5'd7; id_use_rm = 1'b1;
        #1;
        check("rm_hazard", d_bub, 1);
        id_use_rm = 1'b0;
        #1;
        check("rm_unused", d_bub, 0);
        ex_readmem = 1'b0; id_use_rm = 1'b1;
        #1;
        check("not_a_load", d_bub, 0);
        clear_inputs();
        tick();
        check("xzr_events", d_se, 1);

        // Branch together with a hazard: flush wins, no stall counted.
        pulse_reset();
        load_use_rn2();
        en_jump = 1'b1;
        #1;
        check("br_flush", {d_fif, d_fie, d_fem}, 3'b111);
        check("br_no_stall", {d_pc, d_bub}, 2'b10);
        tick();
        clear_inputs();
        #1;
        check("br_events", {d_fe, d_se}, {16'd1, 16'd0});
        check("br_flush_done", {d_fif, d_fie, d_fem}, 3'b000);
        check("fc3_flush_c2", {s_fif, s_fie, s_fem}, 3'b111);
        load_use_rn2();
        #1;
        check("fc3_hz_ignored", {s_pc, s_bub}, 2'b10);
        clear_inputs();
        tick();
        check("fc3_flush_c3", s_fif, 1);
        tick();
        check("fc3_run", s_fif, 0);
        check("fc3_events", {s_fe, s_se}, 8'h10);

        // Forwarding priority and XZR exclusion.
        ex_rn = 5'd5; ex_rm = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
        check("fwd_a_mem", d_fa, 2'b10);
        check("fwd_b_mem", d_fb, 2'b10);
        mem_regwrite = 1'b0;
        #1;
        check("fwd_a_wb", d_fa, 2'b01);
        ex_rm = 5'd6;
        #1;
        check("fwd_b_none", d_fb, 2'b00);
        ex_rn = 5'd31; mem_rd = 5'd31; wb_rd = 5'd31; mem_regwrite = 1'b1;
        #1;
        check("fwd_xzr", {d_fa, d_fb}, 4'b0000);
        clear_inputs();

        // Reset on the second stall cycle of the 3-cycle instance.
        pulse_reset();
        load_use_rn2();
        tick();
        clear_inputs();
        #1;
        check("mid_stall", s_pc, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_default", {s_pc, s_ifid, s_bub}, 3'b110);
        reset = 1'b0;
        #1;
        check("mid_rst_run", {s_pc, s_bub}, 2'b10);
        tick();
        check("mid_rst_no_residual", {s_pc, s_bub}, 2'b10);

        // 2^4+3 hazards: small counter saturates, 16-bit counter does not.
        for (int i = 0; i < 19; i++) begin
            load_use_rn2();
            tick();
            clear_inputs();
            tick();
            tick();
        end
        check("sat_small", s_se, 4'hf);
        check("sat_default", d_se, 19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
